// File: rtl/id_hazard_if.sv
// Signal bundle between the pipeline datapath and id_hazard_ctrl: D/E/M/W stage
// status in, stall/flush/forwarding control and mul/div scoreboard state out.
interface id_hazard_if #(
  parameter int REG_AW = 5
);
  logic              instrValidD;
  logic [REG_AW-1:0] rs1AddrD, rs2AddrD, rdD;
  logic              rs1UsedD, rs2UsedD, regWriteEnD, mulDivD;
  logic [REG_AW-1:0] rs1AddrE, rs2AddrE, rdE;
  logic              regWriteEnE, memReadE, branchTakenE;
  logic [REG_AW-1:0] rdM, rdW;
  logic              regWriteEnM, regWriteEnW;
  logic              stallF, stallD, flushD, flushE;
  logic [1:0]        fwdASelE, fwdBSelE;
  logic              mdStartE, mdBusy, mdWbSelW;
  logic [REG_AW-1:0] mdRd;
  logic [31:0]       perfStallCnt, perfFlushCnt;

  modport master (
    output instrValidD, rs1AddrD, rs2AddrD, rdD, rs1UsedD, rs2UsedD, regWriteEnD, mulDivD,
           rs1AddrE, rs2AddrE, rdE, regWriteEnE, memReadE, branchTakenE,
           rdM, rdW, regWriteEnM, regWriteEnW,
    input  stallF, stallD, flushD, flushE, fwdASelE, fwdBSelE,
           mdStartE, mdBusy, mdWbSelW, mdRd, perfStallCnt, perfFlushCnt
  );

  modport slave (
    input  instrValidD, rs1AddrD, rs2AddrD, rdD, rs1UsedD, rs2UsedD, regWriteEnD, mulDivD,
           rs1AddrE, rs2AddrE, rdE, regWriteEnE, memReadE, branchTakenE,
           rdM, rdW, regWriteEnM, regWriteEnW,
    output stallF, stallD, flushD, flushE, fwdASelE, fwdBSelE,
           mdStartE, mdBusy, mdWbSelW, mdRd, perfStallCnt, perfFlushCnt
  );
endinterface

// File: rtl/id_hazard_ctrl.sv
// ID-stage hazard controller: stalls/flushes, EX forwarding, single-entry mul/div
// scoreboard and W write-port arbitration. Define HAZARD_PERF_EN for perf counters.
module id_hazard_ctrl #(
  parameter int MULDIV_LAT = 8,
  parameter int STARVE_LIM = 4,
  parameter int REG_AW     = 5
) (
  input logic       clk,
  input logic       resetn,
  id_hazard_if.slave hz
);
  localparam int CNT_W  = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
  localparam int WCNT_W = $clog2(STARVE_LIM + 1) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, WB_REQ} state_t;

  state_t            state, stateNext;
  logic [CNT_W-1:0]  cnt, cntNext;
  logic [WCNT_W-1:0] wcnt, wcntNext;
  logic              busyQ, startQ;
  logic [REG_AW-1:0] rdQ;
  logic              loadUse, sbHaz, structHaz, bubble, anyStall;
  logic              stallInt, issue, grant;
  logic [REG_AW-1:0] wbRd;
  logic              wbEn;

  function automatic logic [1:0] fwdSel(input logic [REG_AW-1:0] src,
                                        input logic mEn, input logic [REG_AW-1:0] mRd,
                                        input logic wEn, input logic [REG_AW-1:0] wRd);
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (mEn && (mRd == src))      sel = 2'b10;
      else if (wEn && (wRd == src)) sel = 2'b01;
    end
    return sel;
  endfunction

  // Hazard detection and pipeline control
  always_comb begin
    loadUse   = hz.memReadE & hz.regWriteEnE & (hz.rdE != '0) &
                ((hz.rs1UsedD & (hz.rs1AddrD == hz.rdE)) |
                 (hz.rs2UsedD & (hz.rs2AddrD == hz.rdE)));
    sbHaz     = hz.instrValidD & busyQ & (rdQ != '0) &
                ((hz.rs1UsedD & (hz.rs1AddrD == rdQ)) |
                 (hz.rs2UsedD & (hz.rs2AddrD == rdQ)) |
                 (hz.regWriteEnD & (hz.rdD == rdQ)));
    structHaz = hz.instrValidD & hz.mulDivD & (state != IDLE);
    grant     = (state == WB_REQ) & ~hz.regWriteEnW;
    // Bubbles drain the single-cycle pipe so W eventually frees up for the mul/div result.
    bubble    = (state == WB_REQ) & hz.regWriteEnW & (wcnt >= WCNT_W'(STARVE_LIM));
    anyStall  = loadUse | sbHaz | structHaz | bubble;
    stallInt  = resetn & ~hz.branchTakenE & anyStall;
    issue     = hz.instrValidD & hz.mulDivD & ~stallInt & ~hz.branchTakenE & (state == IDLE);
  end

  assign hz.stallF = stallInt;
  assign hz.stallD = stallInt;
  assign hz.flushD = resetn & hz.branchTakenE;
  assign hz.flushE = resetn & (hz.branchTakenE | anyStall);

  // EX forwarding; W source is whichever unit owns the write port this cycle
  assign wbRd        = grant ? rdQ : hz.rdW;
  assign wbEn        = grant | hz.regWriteEnW;
  assign hz.fwdASelE = fwdSel(hz.rs1AddrE, hz.regWriteEnM, hz.rdM, wbEn, wbRd);
  assign hz.fwdBSelE = fwdSel(hz.rs2AddrE, hz.regWriteEnM, hz.rdM, wbEn, wbRd);

  // Mul/div scoreboard FSM
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    wcntNext  = wcnt;
    case (state)
      IDLE: begin
        if (issue) begin
          stateNext = BUSY;
          cntNext   = CNT_W'(MULDIV_LAT - 1);
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          stateNext = WB_REQ;
          wcntNext  = '0;
        end else begin
          cntNext = cnt - 1'b1;
        end
      end
      WB_REQ: begin
        if (grant)            stateNext = IDLE;
        else if (wcnt != '1)  wcntNext  = wcnt + 1'b1;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      wcnt   <= '0;
      busyQ  <= 1'b0;
      rdQ    <= '0;
      startQ <= 1'b0;
    end else begin
      state  <= stateNext;
      cnt    <= cntNext;
      wcnt   <= wcntNext;
      startQ <= issue;
      if (issue) begin
        busyQ <= 1'b1;
        rdQ   <= hz.rdD;
      end else if (grant) begin
        busyQ <= 1'b0;
      end
    end
  end

  assign hz.mdBusy   = busyQ;
  assign hz.mdRd     = rdQ;
  assign hz.mdStartE = startQ;
  assign hz.mdWbSelW = grant;

`ifdef HAZARD_PERF_EN
  logic [31:0] stallCnt, flushCnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (stallInt)        stallCnt <= stallCnt + 32'd1;
      if (hz.branchTakenE) flushCnt <= flushCnt + 32'd1;
    end
  end

  assign hz.perfStallCnt = stallCnt;
  assign hz.perfFlushCnt = flushCnt;
`else
  assign hz.perfStallCnt = '0;
  assign hz.perfFlushCnt = '0;
`endif
endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl with a grant scoreboard for mul/div write-backs.
module tb_id_hazard_ctrl;
  localparam int LAT  = 8;
  localparam int SLIM = 4;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  id_hazard_if #(.REG_AW(AW)) hz();
  id_hazard_ctrl #(.MULDIV_LAT(LAT), .STARVE_LIM(SLIM), .REG_AW(AW)) dut (
    .clk(clk), .resetn(resetn), .hz(hz)
  );

  typedef struct {
    logic [AW-1:0] rd;
    int            cyc;
  } grant_t;

  grant_t expQ[$];
  int nCmp = 0, nFail = 0, cyc = 0, flushExp = 0, stallExp = 0;
  int startCyc, n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chkB(input string tag, input logic obs, input logic exp);
    chk(tag, {31'd0, obs}, {31'd0, exp});
  endtask

  // Samples mid-cycle (inputs settled), then advances one clock.
  task automatic tick();
    grant_t g;
    @(negedge clk);
    if (resetn === 1'b1 && hz.branchTakenE === 1'b1) flushExp++;
    if (hz.mdWbSelW !== 1'b0) begin
      chkB("grant_expected", expQ.size() != 0, 1'b1);
      if (expQ.size() != 0) begin
        g = expQ.pop_front();
        chk("grant_rd", 32'(hz.mdRd), 32'(g.rd));
        chk("grant_cycle", cyc, g.cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clearIns();
    hz.instrValidD = 0; hz.rs1AddrD = 0; hz.rs2AddrD = 0; hz.rdD = 0;
    hz.rs1UsedD = 0; hz.rs2UsedD = 0; hz.regWriteEnD = 0; hz.mulDivD = 0;
    hz.rs1AddrE = 0; hz.rs2AddrE = 0; hz.rdE = 0;
    hz.regWriteEnE = 0; hz.memReadE = 0; hz.branchTakenE = 0;
    hz.rdM = 0; hz.rdW = 0; hz.regWriteEnM = 0; hz.regWriteEnW = 0;
  endtask

  task automatic setLoadUse();
    hz.memReadE = 1; hz.regWriteEnE = 1; hz.rdE = 5;
    hz.instrValidD = 1; hz.rs1AddrD = 5; hz.rs1UsedD = 1;
  endtask

  initial begin
    clearIns();
    resetn = 1'b1;
    #1 resetn = 1'b0;
    setLoadUse();
    hz.branchTakenE = 1;
    #2;
    chkB("rst_stallF", hz.stallF, 1'b0);
    chkB("rst_stallD", hz.stallD, 1'b0);
    chkB("rst_flushD", hz.flushD, 1'b0);
    chkB("rst_flushE", hz.flushE, 1'b0);
    chkB("rst_mdBusy", hz.mdBusy, 1'b0);
    chk ("rst_mdRd", 32'(hz.mdRd), 32'd0);
    chkB("rst_mdStartE", hz.mdStartE, 1'b0);
    chkB("rst_mdWbSelW", hz.mdWbSelW, 1'b0);
    clearIns();
    tick(); tick();
    resetn = 1'b1;
    #1;
    chk("rst_perfStall", hz.perfStallCnt, 32'd0);
    chk("rst_perfFlush", hz.perfFlushCnt, 32'd0);

    // Load-use
    setLoadUse();
    #1;
    chkB("lu_stallF", hz.stallF, 1'b1);
    chkB("lu_stallD", hz.stallD, 1'b1);
    chkB("lu_flushE", hz.flushE, 1'b1);
    chkB("lu_flushD", hz.flushD, 1'b0);
    tick(); stallExp++;
    hz.memReadE = 0; hz.regWriteEnE = 0; hz.rdE = 0;
    #1 chkB("lu_one_cycle", hz.stallD, 1'b0);
    hz.memReadE = 1; hz.regWriteEnE = 1; hz.rdE = 0; hz.rs1AddrD = 0;
    #1 chkB("lu_x0_stallD", hz.stallD, 1'b0);
    chkB("lu_x0_flushE", hz.flushE, 1'b0);
    hz.rdE = 5; hz.rs1AddrD = 1; hz.rs2AddrD = 5; hz.rs2UsedD = 0;
    #1 chkB("lu_rs2_unused", hz.stallD, 1'b0);
    hz.rs2UsedD = 1;
    #1 chkB("lu_rs2_used", hz.stallD, 1'b1);
    tick(); stallExp++;
    clearIns();

    // Forwarding
    hz.regWriteEnM = 1; hz.rdM = 7; hz.regWriteEnW = 1; hz.rdW = 7;
    hz.rs1AddrE = 7; hz.rs2AddrE = 0;
    #1 chk("fwdA_M_over_W", 32'(hz.fwdASelE), 32'd2);
    chk("fwdB_x0", 32'(hz.fwdBSelE), 32'd0);
    hz.regWriteEnM = 0;
    #1 chk("fwdA_W", 32'(hz.fwdASelE), 32'd1);
    hz.regWriteEnW = 0;
    #1 chk("fwdA_none", 32'(hz.fwdASelE), 32'd0);
    hz.rs2AddrE = 3; hz.rdW = 3; hz.regWriteEnW = 1;
    #1 chk("fwdB_W", 32'(hz.fwdBSelE), 32'd1);
    hz.rs1AddrE = 0; hz.rdM = 0; hz.regWriteEnM = 1; hz.rdW = 0;
    #1 chk("fwdA_x0_M", 32'(hz.fwdASelE), 32'd0);
    clearIns();

    // Branch overrides stall and blocks mul/div issue
    setLoadUse();
    hz.branchTakenE = 1; hz.mulDivD = 1; hz.rdD = 6; hz.regWriteEnD = 1;
    #1;
    chkB("br_flushD", hz.flushD, 1'b1);
    chkB("br_flushE", hz.flushE, 1'b1);
    chkB("br_stallF", hz.stallF, 1'b0);
    chkB("br_stallD", hz.stallD, 1'b0);
    tick();
    clearIns();
    #1;
    chkB("br_no_start", hz.mdStartE, 1'b0);
    chkB("br_no_busy", hz.mdBusy, 1'b0);
`ifdef HAZARD_PERF_EN
    chk("perf_flush", hz.perfFlushCnt, flushExp);
    chk("perf_stall", hz.perfStallCnt, stallExp);
`else
    chk("perf_flush_off", hz.perfFlushCnt, 32'd0);
    chk("perf_stall_off", hz.perfStallCnt, 32'd0);
`endif

    // Mul/div with free W port, dependent instruction behind it
    hz.instrValidD = 1; hz.mulDivD = 1; hz.rdD = 9; hz.regWriteEnD = 1;
    #1 chkB("md_issue_nostall", hz.stallD, 1'b0);
    expQ.push_back('{rd: 5'd9, cyc: cyc + 1 + LAT});
    tick();
    chkB("md_start", hz.mdStartE, 1'b1);
    chkB("md_busy", hz.mdBusy, 1'b1);
    chk ("md_rd", 32'(hz.mdRd), 32'd9);
    hz.mulDivD = 0; hz.regWriteEnD = 0; hz.rdD = 0; hz.rs2AddrD = 9; hz.rs2UsedD = 1;
    #1 chkB("md_raw_stall0", hz.stallD, 1'b1);
    tick();
    chkB("md_start_pulse", hz.mdStartE, 1'b0);
    n = 0;
    for (int i = 0; i < 30 && hz.mdBusy; i++) begin
      chkB("md_raw_stall", hz.stallD, 1'b1);
      tick();
      n++;
    end
    chk ("md_busy_span", n, LAT);
    chkB("md_busy_clear", hz.mdBusy, 1'b0);
    chkB("md_raw_release", hz.stallD, 1'b0);
    chk ("md_grant_seen", expQ.size(), 32'd0);
    clearIns();

    // Starvation bubbles and structural stall
    hz.instrValidD = 1; hz.mulDivD = 1; hz.rdD = 12; hz.regWriteEnD = 1;
    tick();
    startCyc = cyc;
    hz.rdD = 3;
    #1 chkB("struct_stallD", hz.stallD, 1'b1);
    chkB("struct_stallF", hz.stallF, 1'b1);
    hz.instrValidD = 0; hz.mulDivD = 0; hz.regWriteEnD = 0;
    hz.regWriteEnW = 1; hz.rdW = 4;
    tick();
    chkB("struct_no_issue", hz.mdStartE, 1'b0);
    chk ("struct_keep_rd", 32'(hz.mdRd), 32'd12);
    while (cyc < startCyc + LAT) tick();
    for (int w = 0; w < SLIM; w++) begin
      chkB("starve_no_bubble", hz.stallF, 1'b0);
      tick();
    end
    chkB("starve_bubble_stallF", hz.stallF, 1'b1);
    chkB("starve_bubble_stallD", hz.stallD, 1'b1);
    chkB("starve_bubble_flushE", hz.flushE, 1'b1);
    chkB("starve_busy", hz.mdBusy, 1'b1);
    tick();
    chkB("starve_bubble_hold", hz.stallD, 1'b1);
    hz.regWriteEnW = 0; hz.rs1AddrE = 12;
    #1 chkB("starve_grant", hz.mdWbSelW, 1'b1);
    chk("fwdA_md_wb", 32'(hz.fwdASelE), 32'd1);
    expQ.push_back('{rd: 5'd12, cyc: cyc});
    tick();
    chkB("starve_busy_clear", hz.mdBusy, 1'b0);
    chk ("starve_grant_seen", expQ.size(), 32'd0);
    clearIns();

    // Asynchronous reset while BUSY
    hz.instrValidD = 1; hz.mulDivD = 1; hz.rdD = 15; hz.regWriteEnD = 1;
    tick();
    clearIns();
    tick(); tick();
    setLoadUse();
    #1 chkB("ar_pre_stall", hz.stallD, 1'b1);
    chkB("ar_pre_busy", hz.mdBusy, 1'b1);
    #1 resetn = 1'b0;
    #1;
    chkB("ar_stallD", hz.stallD, 1'b0);
    chkB("ar_flushE", hz.flushE, 1'b0);
    chkB("ar_busy", hz.mdBusy, 1'b0);
    chk ("ar_rd", 32'(hz.mdRd), 32'd0);
    tick();
    clearIns();
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chkB("ar_post_busy", hz.mdBusy, 1'b0);
    chk ("ar_no_grant", expQ.size(), 32'd0);
    chk ("ar_perfStall", hz.perfStallCnt, 32'd0);
    chk ("ar_perfFlush", hz.perfFlushCnt, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
